// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Arbitrates a single register-file write port between a pipeline writeback
//   source (port A, can be stalled) and a multicycle unit (port B, buffered in a
//   2-entry FIFO). Port A normally has priority; port B is forced through after
//   STARVE_LIMIT consecutive lost cycles. Writes to address 0 are consumed but
//   never issued.
//
//   Optional feature: define REGFILE_ARB_BYPASS_EN to add a forwarding lookup
//   (fwd_addr/fwd_hit/fwd_data) over the FIFO contents and the registered write.
//
// Ports
//   clk, rst               clock; asynchronous active-high reset
//   a_valid/a_addr/a_data  port A write request
//   a_stall                combinational; A must hold its request while high
//   b_valid/b_addr/b_data  port B write request
//   b_ready                B transfer when b_valid && b_ready at posedge
//   WE3/AD3/WD3            registered register-file write port
//   busy                   B FIFO non-empty
//   fwd_addr/fwd_hit/fwd_data  forwarding lookup (REGFILE_ARB_BYPASS_EN only)
module regfile_write_arbiter #(
   parameter int unsigned WIDTH        = 5,
   parameter int unsigned DATAWIDTH    = 32,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 a_valid,
   input  logic [WIDTH-1:0]     a_addr,
   input  logic [DATAWIDTH-1:0] a_data,
   output logic                 a_stall,
   input  logic                 b_valid,
   input  logic [WIDTH-1:0]     b_addr,
   input  logic [DATAWIDTH-1:0] b_data,
   output logic                 b_ready,
   output logic                 WE3,
   output logic [WIDTH-1:0]     AD3,
   output logic [DATAWIDTH-1:0] WD3,
   output logic                 busy
`ifdef REGFILE_ARB_BYPASS_EN
   ,
   input  logic [WIDTH-1:0]     fwd_addr,
   output logic                 fwd_hit,
   output logic [DATAWIDTH-1:0] fwd_data
`endif
);

   localparam int unsigned SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

   typedef struct packed {
      logic [WIDTH-1:0]     addr;
      logic [DATAWIDTH-1:0] data;
   } entry_t;

   entry_t               mem_q [2];
   entry_t               mem_d [2];
   logic                 rd_ptr_q, rd_ptr_d;
   logic                 wr_ptr_q, wr_ptr_d;
   logic [1:0]           count_q, count_d;
   logic [SW-1:0]        starve_q, starve_d;
   logic                 we3_q, we3_d;
   logic [WIDTH-1:0]     ad3_q, ad3_d;
   logic [DATAWIDTH-1:0] wd3_q, wd3_d;

   logic   fifo_empty;
   logic   head_grant;
   logic   a_grant;
   logic   push;
   entry_t head;

   // Grant decision uses only registered FIFO state, so a same-cycle push
   // cannot be granted until the following cycle.
   assign fifo_empty = (count_q == 2'd0);
   assign head       = mem_q[rd_ptr_q];
   assign head_grant = !fifo_empty && (!a_valid || (starve_q == SW'(STARVE_LIMIT)));
   assign a_grant    = a_valid && !head_grant;
   assign b_ready    = (count_q < 2'd2);
   assign push       = b_valid && b_ready;
   assign a_stall    = a_valid && head_grant;
   assign busy       = !fifo_empty;

   assign WE3 = we3_q;
   assign AD3 = ad3_q;
   assign WD3 = wd3_q;

   // FIFO, starvation counter and write-port next state
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      starve_d = starve_q;
      we3_d    = 1'b0;
      ad3_d    = ad3_q;
      wd3_d    = wd3_q;

      if (push) begin
         mem_d[wr_ptr_q] = '{addr: b_addr, data: b_data};
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (head_grant) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end

      case ({push, head_grant})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase

      if (fifo_empty || head_grant) begin
         starve_d = '0;
      end else if (starve_q != SW'(STARVE_LIMIT)) begin
         starve_d = starve_q + SW'(1);
      end

      // Address 0 is consumed (popped / not stalled) but never written.
      if (head_grant) begin
         if (head.addr != '0) begin
            we3_d = 1'b1;
            ad3_d = head.addr;
            wd3_d = head.data;
         end
      end else if (a_grant) begin
         if (a_addr != '0) begin
            we3_d = 1'b1;
            ad3_d = a_addr;
            wd3_d = a_data;
         end
      end
   end

   // State registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
         starve_q <= '0;
         we3_q    <= 1'b0;
         ad3_q    <= '0;
         wd3_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         starve_q <= starve_d;
         we3_q    <= we3_d;
         ad3_q    <= ad3_d;
         wd3_q    <= wd3_d;
      end
   end

`ifdef REGFILE_ARB_BYPASS_EN
   // Youngest match wins: FIFO tail, then FIFO head, then the in-flight write.
   // With one entry the head is also the tail; the tail entry only exists
   // separately when the FIFO is full.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      if (fwd_addr != '0) begin
         if ((count_q == 2'd2) && (mem_q[~rd_ptr_q].addr == fwd_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = mem_q[~rd_ptr_q].data;
         end else if (!fifo_empty && (head.addr == fwd_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = head.data;
         end else if (we3_q && (ad3_q == fwd_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = wd3_q;
         end
      end
   end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: a queue-based reference model
// predicts grants; expected writes are queued with the cycle they must appear
// in and a separate negedge monitor pops and compares them.
module tb_regfile_write_arbiter;

   localparam int unsigned AW = 5;
   localparam int unsigned DW = 32;
   localparam int          SL = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          a_valid = 1'b0;
   logic [AW-1:0] a_addr = '0;
   logic [DW-1:0] a_data = '0;
   logic          a_stall;
   logic          b_valid = 1'b0;
   logic [AW-1:0] b_addr = '0;
   logic [DW-1:0] b_data = '0;
   logic          b_ready;
   logic          WE3;
   logic [AW-1:0] AD3;
   logic [DW-1:0] WD3;
   logic          busy;
`ifdef REGFILE_ARB_BYPASS_EN
   logic [AW-1:0] fwd_addr = '0;
   logic          fwd_hit;
   logic [DW-1:0] fwd_data;
`endif

   regfile_write_arbiter #(.WIDTH(AW), .DATAWIDTH(DW), .STARVE_LIMIT(SL)) dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_stall(a_stall),
      .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
      .WE3(WE3), .AD3(AD3), .WD3(WD3), .busy(busy)
`ifdef REGFILE_ARB_BYPASS_EN
      , .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int            stamp;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } ent_t;

   wr_t           exp_q[$];
   ent_t          bq[$];
   int            starve = 0;
   int            cyc = 0;
   int            checks = 0;
   int            failures = 0;
   logic [AW-1:0] last_ad = '0;
   logic [DW-1:0] last_wd = '0;
   bit            mdl_we = 1'b0;
   bit            stall_prev = 1'b0;

   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Monitor: compares the registered write port with the scoreboard.
   always @(negedge clk) begin
      if (!rst) begin
         bit ew;
         ew = (exp_q.size() > 0) && (exp_q[0].stamp == cyc);
         chk("we3", WE3, DW'(ew));
         if (ew) begin
            chk("ad3", DW'(AD3), DW'(exp_q[0].addr));
            chk("wd3", WD3, exp_q[0].data);
            last_ad = exp_q[0].addr;
            last_wd = exp_q[0].data;
            void'(exp_q.pop_front());
         end else begin
            chk("ad3_hold", DW'(AD3), DW'(last_ad));
            chk("wd3_hold", WD3, last_wd);
         end
         mdl_we = ew;
      end
   end

   // Reference model: checks combinational outputs for the current inputs and
   // advances the abstract state across the coming posedge.
   task automatic model();
      bit   empty, bready, hw, stall, g;
      ent_t w;
      empty  = (bq.size() == 0);
      bready = (bq.size() < 2);
      hw     = !empty && (!a_valid || starve == SL);
      stall  = a_valid && hw;
      chk("a_stall", DW'(a_stall), DW'(stall));
      chk("b_ready", DW'(b_ready), DW'(bready));
      chk("busy", DW'(busy), DW'(!empty));
`ifdef REGFILE_ARB_BYPASS_EN
      begin
         bit            eh;
         logic [DW-1:0] ed;
         eh = 1'b0;
         ed = '0;
         if (fwd_addr != '0) begin
            for (int i = bq.size() - 1; i >= 0; i--) begin
               if (!eh && bq[i].addr == fwd_addr) begin
                  eh = 1'b1;
                  ed = bq[i].data;
               end
            end
            if (!eh && mdl_we && last_ad == fwd_addr) begin
               eh = 1'b1;
               ed = last_wd;
            end
         end
         chk("fwd_hit", DW'(fwd_hit), DW'(eh));
         chk("fwd_data", fwd_data, ed);
      end
`endif
      g = 1'b0;
      w = '{addr: '0, data: '0};
      if (hw) begin
         w = bq.pop_front();
         g = 1'b1;
      end else if (a_valid) begin
         w = '{addr: a_addr, data: a_data};
         g = 1'b1;
      end
      if (g && w.addr != '0) exp_q.push_back('{stamp: cyc + 1, addr: w.addr, data: w.data});
      if (empty || hw) starve = 0;
      else if (starve < SL) starve = starve + 1;
      if (b_valid && bready) bq.push_back('{addr: b_addr, data: b_data});
      stall_prev = stall;
   endtask

   task automatic step(input bit av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input bit bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                       input logic [AW-1:0] fa);
      @(negedge clk);
      a_valid = av; a_addr = aa; a_data = ad;
      b_valid = bv; b_addr = ba; b_data = bd;
`ifdef REGFILE_ARB_BYPASS_EN
      fwd_addr = fa;
`endif
      #1;
      model();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0, '0);
   endtask

   // Mid-cycle asynchronous reset: outputs must clear without a clock edge.
   task automatic do_reset();
      @(negedge clk);
      #3 rst = 1'b1;
      #1;
      chk("rst_we3", DW'(WE3), '0);
      chk("rst_ad3", DW'(AD3), '0);
      chk("rst_wd3", WD3, '0);
      chk("rst_b_ready", DW'(b_ready), DW'(1));
      chk("rst_busy", DW'(busy), '0);
      chk("rst_a_stall", DW'(a_stall), '0);
      exp_q.delete();
      bq.delete();
      starve = 0;
      last_ad = '0;
      last_wd = '0;
      mdl_we = 1'b0;
      stall_prev = 1'b0;
      a_valid = 1'b0; b_valid = 1'b0;
      repeat (2) @(negedge clk);
      #3 rst = 1'b0;
   endtask

   initial begin
      bit            av, bv;
      logic [AW-1:0] aa, ba, fa;
      logic [DW-1:0] ad, bd;

      #2 rst = 1'b1;
      #1;
      chk("init_we3", DW'(WE3), '0);
      chk("init_b_ready", DW'(b_ready), DW'(1));
      chk("init_busy", DW'(busy), '0);
      repeat (2) @(negedge clk);
      #3 rst = 1'b0;

      // Single A write into an idle arbiter
      step(1'b1, 5'd3, 32'h11, 1'b0, '0, '0, 5'd3);
      idle(2);

      // Two B pushes with A idle, then the same with A busy so the FIFO fills
      step(1'b0, '0, '0, 1'b1, 5'd7, 32'hAA, 5'd7);
      step(1'b0, '0, '0, 1'b1, 5'd8, 32'hBB, 5'd8);
      idle(3);
      step(1'b1, 5'd1, 32'h1, 1'b1, 5'd7, 32'hAA, 5'd7);
      step(1'b1, 5'd2, 32'h2, 1'b1, 5'd8, 32'hBB, 5'd8);
      step(1'b0, '0, '0, 1'b1, 5'd6, 32'h66, 5'd8);
      idle(4);

      // Starvation: B entry waits behind a continuous A stream
      step(1'b0, '0, '0, 1'b1, 5'd9, 32'h99, 5'd9);
      for (int i = 0; i < 7; i++) step(1'b1, 5'd4, 32'h40, 1'b0, '0, '0, 5'd4);
      idle(2);

      // Address-0 writes are dropped, from either port
      step(1'b1, 5'd0, 32'hFF, 1'b0, '0, '0, 5'd0);
      step(1'b0, '0, '0, 1'b1, 5'd0, 32'hEE, 5'd0);
      idle(3);

`ifdef REGFILE_ARB_BYPASS_EN
      // Same address twice in the FIFO: the younger entry forwards
      step(1'b1, 5'd2, 32'h3, 1'b1, 5'd5, 32'h1, 5'd5);
      step(1'b1, 5'd2, 32'h4, 1'b1, 5'd5, 32'h2, 5'd5);
      step(1'b1, 5'd2, 32'h5, 1'b0, '0, '0, 5'd5);
      step(1'b1, 5'd2, 32'h6, 1'b0, '0, '0, 5'd0);
      idle(4);
`endif

      // Flush two queued B entries with a reset
      step(1'b1, 5'd10, 32'hA0, 1'b1, 5'd12, 32'hC0, 5'd12);
      step(1'b1, 5'd11, 32'hA1, 1'b1, 5'd13, 32'hC1, 5'd13);
      do_reset();
      idle(4);

      // Randomized traffic; a stalled A request is held unchanged
      av = 1'b0; aa = '0; ad = '0;
      for (int i = 0; i < 600; i++) begin
         if (!stall_prev) begin
            av = ($urandom_range(0, 99) < 60);
            aa = AW'($urandom_range(0, 7));
            ad = $urandom;
         end
         bv = ($urandom_range(0, 1) == 1);
         ba = AW'($urandom_range(0, 7));
         bd = $urandom;
         fa = AW'($urandom_range(0, 7));
         step(av, aa, ad, bv, ba, bd, fa);
         if (i == 300) do_reset();
      end
      idle(6);
      chk("drain", DW'(exp_q.size()), '0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
